atsc_tx_mapper: RTL and testbench

ATSC_TX_MAPPER -- requirements
Module: atsc_tx_mapper

---
 rtl/atsc_tx_pkg.sv | 25 ++
 rtl/atsc_tx_level_map.sv | 34 +++
 rtl/atsc_tx_mapper.sv | 140 ++++++++++++++
 tb/tb_atsc_tx_mapper.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atsc_tx_pkg.sv
// Shared constants for the ATSC 8VSB transmit mapper: segment geometry,
// the segment sync pattern and the default settings-bus addresses.
package atsc_tx_pkg;

    localparam int unsigned SEG_LEN       = 832;
    localparam int unsigned SYNC_LEN      = 4;
    localparam int unsigned SEG_PER_FIELD = 313;

    localparam logic [7:0]  DEF_CTRL_ADDR = 8'd128;
    localparam logic [7:0]  DEF_GAIN_ADDR = 8'd129;
    localparam logic [11:0] DEF_GAIN      = 12'd1024;

    localparam logic signed [3:0] SYNC_LEVEL [0:3] = '{4'sd5, -4'sd5, -4'sd5, 4'sd5};

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_DATA = 1'b1
    } tx_state_e;

    // 2*sym-7 equals {sym,1} - 8, i.e. {sym,1} with its sign bit flipped.
    function automatic logic signed [3:0] sym_to_level(input logic [2:0] sym);
        return {~sym[2], sym[1:0], 1'b1};
    endfunction

endpackage

// File: rtl/atsc_tx_level_map.sv
// Combinational mapping of a signed 8VSB level to a saturated 16-bit I sample:
// level*gain plus an optional pilot offset of 1.25*gain.
module atsc_tx_level_map (
    input  logic signed [3:0]  level_i,
    input  logic        [11:0] gain_i,
    input  logic               pilot_en_i,
    output logic        [15:0] i_o
);

    logic signed [17:0] level_s;
    logic signed [17:0] gain_s;
    logic signed [17:0] prod_s;
    logic signed [17:0] pilot_s;
    logic signed [17:0] sum_s;
    logic        [17:0] gain5;

    // 18 bits covers the worst case 7*4095 + 5118 without wrap.
    always_comb begin
        level_s = {{14{level_i[3]}}, level_i};
        gain_s  = {6'd0, gain_i};
        prod_s  = level_s * gain_s;
        gain5   = {6'd0, gain_i} * 18'd5;
        pilot_s = pilot_en_i ? $signed(gain5 >> 2) : 18'sd0;
        sum_s   = prod_s + pilot_s;
        if (sum_s > 18'sd32767) begin
            i_o = 16'h7fff;
        end else if (sum_s < -18'sd32768) begin
            i_o = 16'h8000;
        end else begin
            i_o = sum_s[15:0];
        end
    end

endmodule

// File: rtl/atsc_tx_mapper.sv
// ATSC 8VSB segment builder: inserts the 4-word segment sync, maps input
// symbols to scaled I samples and emits one registered AXIS word per load.
module atsc_tx_mapper
    import atsc_tx_pkg::*;
#(
    parameter logic [7:0]  SR_CTRL_ADDR = DEF_CTRL_ADDR,
    parameter logic [7:0]  SR_GAIN_ADDR = DEF_GAIN_ADDR,
    parameter int unsigned SEG_WRAP     = SEG_PER_FIELD
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] in_tdata,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [31:0] out_tdata,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [8:0]  seg_count,
    output logic        dbg_state
);

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high; a source holding valid keeps its data stable until then.

    localparam logic [9:0] LAST_IDX  = 10'(SEG_LEN - 1);
    localparam logic [9:0] LAST_SYNC = 10'(SYNC_LEN - 1);
    localparam logic [8:0] LAST_SEG  = 9'(SEG_WRAP - 1);

    tx_state_e   state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [8:0]  seg_q, seg_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [11:0] gain_q, gain_d;
    logic        valid_q, valid_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;

    logic              enable;
    logic              out_free;
    logic              load;
    logic signed [3:0] level;
    logic [15:0]       i_sample;

    assign enable = ctrl_q[0];

    atsc_tx_level_map u_level_map (
        .level_i    (level),
        .gain_i     (gain_q),
        .pilot_en_i (ctrl_q[1]),
        .i_o        (i_sample)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seg_d     = seg_q;
        ctrl_d    = ctrl_q;
        gain_d    = gain_q;
        valid_d   = valid_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        in_tready = 1'b0;
        load      = 1'b0;
        out_free  = !valid_q || out_tready;
        level     = SYNC_LEVEL[idx_q[1:0]];

        if (set_stb && set_addr == SR_CTRL_ADDR) ctrl_d = set_data[1:0];
        if (set_stb && set_addr == SR_GAIN_ADDR) gain_d = set_data[11:0];

        case (state_q)
            ST_SYNC: begin
                load = enable && out_free;
            end
            ST_DATA: begin
                in_tready = enable && out_free;
                load      = in_tready && in_tvalid;
                level     = sym_to_level(in_tdata[2:0]);
            end
            default: ;
        endcase

        if (valid_q && out_tready) begin
            valid_d = 1'b0;
            if (tlast_q) seg_d = (seg_q == LAST_SEG) ? 9'd0 : seg_q + 9'd1;
        end

        if (load) begin
            valid_d = 1'b1;
            tdata_d = {i_sample, 16'h0000};
            tlast_d = (idx_q == LAST_IDX);
            idx_d   = (idx_q == LAST_IDX) ? 10'd0 : idx_q + 10'd1;
            if (state_q == ST_SYNC && idx_q == LAST_SYNC) state_d = ST_DATA;
            if (state_q == ST_DATA && idx_q == LAST_IDX)  state_d = ST_SYNC;
        end

        // Disabling abandons the segment; a pending word still drains.
        if (!enable) begin
            state_d = ST_SYNC;
            idx_d   = 10'd0;
            seg_d   = 9'd0;
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            state_q <= ST_SYNC;
            idx_q   <= 10'd0;
            seg_q   <= 9'd0;
            ctrl_q  <= 2'b00;
            gain_q  <= DEF_GAIN;
            valid_q <= 1'b0;
            tdata_q <= 32'd0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            ctrl_q  <= ctrl_d;
            gain_q  <= gain_d;
            valid_q <= valid_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

    assign out_tdata  = tdata_q;
    assign out_tlast  = tlast_q;
    assign out_tvalid = valid_q;
    assign seg_count  = seg_q;
    assign dbg_state  = (state_q == ST_DATA);

    logic unused_bits;
    assign unused_bits = ^{set_data[31:12], in_tdata[31:3], in_tlast};

endmodule

// File: tb/tb_atsc_tx_mapper.sv
// Self-checking bench for atsc_tx_mapper: random AXIS traffic scored against
// a segment-level reference model, plus directed sync/saturation/stall/reset cases.
module tb_atsc_tx_mapper;
    import atsc_tx_pkg::*;

    localparam int N_SEG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [31:0] in_tdata = 32'd0;
    logic        in_tlast = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready = 1'b0;
    logic [8:0]  seg_count;
    logic        dbg_state;

    atsc_tx_mapper #(.SEG_WRAP(N_SEG)) dut (
        .ce_clk     (clk),
        .ce_rst     (rst),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .seg_count  (seg_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stimulus knobs (written by the main sequence only)
    int       in_pct = 0;
    int       rdy_pct = 100;
    bit       sym_fix_en = 1'b0;
    bit [2:0] sym_fix = 3'd0;
    bit       flush = 1'b0;
    bit       mon_en = 1'b0;
    int       restart_gen = 0;
    int       gain_m = 1024;
    bit       pilot_m = 1'b0;

    // Monitor / model state (written by the monitor only)
    bit          in_hs_last = 1'b0;
    int          seen_gen = 0;
    int          wpos = 0;
    int          exp_seg = 0;
    int          n_words = 0;
    logic [2:0]  sym_q[$];
    logic [32:0] obs_q[$];
    bit          hold_v = 1'b0;
    logic [32:0] hold_w = '0;
    int          sync_ref [4] = '{5, -5, -5, 5};

    function automatic logic [15:0] exp_i(input int lvl, input int g, input bit p);
        int v;
        v = lvl * g + (p ? (5 * g) / 4 : 0);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Source/sink driver: AXIS source holds a beat until it is taken.
    always @(posedge clk) begin
        logic [2:0] s;
        #1;
        if (!in_tvalid || in_hs_last || flush) begin
            in_tvalid = ($urandom_range(99) < in_pct);
            s = sym_fix_en ? sym_fix : 3'($urandom_range(7));
            in_tdata = {29'($urandom), s};
            in_tlast = 1'($urandom_range(1));
        end
        out_tready = ($urandom_range(99) < rdy_pct);
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int lvl;
        if (restart_gen != seen_gen) begin
            seen_gen = restart_gen;
            wpos = 0;
            exp_seg = 0;
            n_words = 0;
            sym_q.delete();
            obs_q.delete();
        end
        in_hs_last = in_tvalid && in_tready;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(out_tvalid), 64'(1));
                chk("hold_word", 64'({out_tlast, out_tdata}), 64'(hold_w));
            end
            hold_v = out_tvalid && !out_tready;
            hold_w = {out_tlast, out_tdata};
            if (mon_en && in_tvalid && in_tready) sym_q.push_back(in_tdata[2:0]);
            if (mon_en && out_tvalid && out_tready) begin
                if (wpos < 4) begin
                    lvl = sync_ref[wpos];
                end else if (sym_q.size() == 0) begin
                    chk("sym_avail", 64'(0), 64'(1));
                    lvl = 0;
                end else begin
                    lvl = 2 * int'(sym_q.pop_front()) - 7;
                end
                chk("word", 64'({out_tlast, out_tdata}),
                    64'({(wpos == 831), exp_i(lvl, gain_m, pilot_m), 16'h0000}));
                chk("seg", 64'(seg_count), 64'(exp_seg));
                if (obs_q.size() < 832) obs_q.push_back({out_tlast, out_tdata});
                wpos++;
                if (wpos == 832) begin
                    wpos = 0;
                    exp_seg = (exp_seg + 1) % N_SEG;
                end
                n_words++;
            end
        end
    end

    task automatic sr_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = addr; set_data = data;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic restart_model();
        restart_gen++;
        @(negedge clk); #1;
    endtask

    task automatic wait_words(input int target, input int budget);
        int c = 0;
        while (n_words < target && c < budget) begin
            @(posedge clk); #3;
            c++;
        end
        chk("wait_words", 64'(n_words >= target), 64'(1));
    endtask

    task automatic stop_run();
        int c = 0;
        mon_en = 1'b0;
        sr_write(DEF_CTRL_ADDR, 32'd0);
        rdy_pct = 100; in_pct = 0; flush = 1'b1;
        while (out_tvalid && c < 50) begin
            @(posedge clk); #3;
            c++;
        end
        chk("drain", 64'(out_tvalid), 64'(0));
        @(posedge clk); #3;
        flush = 1'b0;
    endtask

    initial begin
        int n_tl;
        logic [31:0] pend;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_tvalid", 64'(out_tvalid), 64'(0));
        chk("rst_tdata", 64'(out_tdata), 64'(0));
        chk("rst_tlast", 64'(out_tlast), 64'(0));
        chk("rst_tready", 64'(in_tready), 64'(0));
        chk("rst_seg", 64'(seg_count), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("idle_tvalid", 64'(out_tvalid), 64'(0));

        // Full segment, pilot on, gain 1024, symbol 7
        restart_model();
        gain_m = 1024; pilot_m = 1'b1; sym_fix_en = 1'b1; sym_fix = 3'd7;
        in_pct = 100; rdy_pct = 100; mon_en = 1'b1;
        sr_write(DEF_GAIN_ADDR, 32'd1024);
        sr_write(DEF_CTRL_ADDR, 32'd3);
        wait_words(832, 3000);
        if (obs_q.size() == 832) begin
            chk("sync0", 64'(obs_q[0]), 64'({1'b0, 32'h19000000}));
            chk("sync1", 64'(obs_q[1]), 64'({1'b0, 32'hF1000000}));
            chk("sync2", 64'(obs_q[2]), 64'({1'b0, 32'hF1000000}));
            chk("sync3", 64'(obs_q[3]), 64'({1'b0, 32'h19000000}));
            chk("data_first", 64'(obs_q[4]), 64'({1'b0, 32'h21000000}));
            chk("data_last", 64'(obs_q[831]), 64'({1'b1, 32'h21000000}));
            n_tl = 0;
            foreach (obs_q[k]) n_tl += int'(obs_q[k][32]);
            chk("tlast_count", 64'(n_tl), 64'(1));
        end
        stop_run();

        // Positive saturation
        restart_model();
        gain_m = 4095; pilot_m = 1'b1; sym_fix = 3'd7; in_pct = 100; mon_en = 1'b1;
        sr_write(DEF_GAIN_ADDR, 32'd4095);
        sr_write(DEF_CTRL_ADDR, 32'd3);
        wait_words(5, 200);
        if (obs_q.size() >= 5) chk("sat_pos", 64'(obs_q[4][31:16]), 64'(16'h7FFF));
        stop_run();

        // Most negative level, no pilot
        restart_model();
        pilot_m = 1'b0; sym_fix = 3'd0; in_pct = 100; mon_en = 1'b1;
        sr_write(DEF_CTRL_ADDR, 32'd1);
        wait_words(5, 200);
        if (obs_q.size() >= 5) chk("neg_full", 64'(obs_q[4][31:16]), 64'(16'h9007));
        stop_run();

        // Random symbols, random backpressure, through the field wrap
        restart_model();
        gain_m = int'($urandom_range(4095)); pilot_m = 1'($urandom_range(1));
        sym_fix_en = 1'b0; in_pct = 70; rdy_pct = 50; mon_en = 1'b1;
        sr_write(DEF_GAIN_ADDR, 32'(gain_m));
        sr_write(DEF_CTRL_ADDR, {30'd0, pilot_m, 1'b1});
        chk("seg_start", 64'(seg_count), 64'(0));
        for (int k = 1; k <= N_SEG + 1; k++) begin
            wait_words(832 * k, 6000);
            chk("seg_after", 64'(seg_count), 64'(k % N_SEG));
        end
        stop_run();

        // Disable while a word is stalled
        restart_model();
        gain_m = 1024; pilot_m = 1'b1; in_pct = 100; rdy_pct = 100; mon_en = 1'b1;
        sr_write(DEF_GAIN_ADDR, 32'd1024);
        sr_write(DEF_CTRL_ADDR, 32'd3);
        wait_words(100, 400);
        rdy_pct = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("pend_valid", 64'(out_tvalid), 64'(1));
        pend = out_tdata;
        mon_en = 1'b0;
        sr_write(DEF_CTRL_ADDR, 32'd0);
        repeat (4) @(posedge clk);
        #3;
        chk("dis_valid", 64'(out_tvalid), 64'(1));
        chk("dis_data", 64'(out_tdata), 64'(pend));
        chk("dis_tready", 64'(in_tready), 64'(0));
        chk("dis_seg", 64'(seg_count), 64'(0));
        chk("dis_state", 64'(dbg_state), 64'(0));
        rdy_pct = 100;
        repeat (3) @(posedge clk);
        #3;
        chk("dis_drained", 64'(out_tvalid), 64'(0));
        restart_model();
        mon_en = 1'b1;
        sr_write(DEF_CTRL_ADDR, 32'd3);
        wait_words(4, 100);
        if (obs_q.size() >= 1) chk("reen_sync", 64'(obs_q[0]), 64'({1'b0, 32'h19000000}));
        chk("reen_seg", 64'(seg_count), 64'(0));

        // Reset mid-segment
        wait_words(500, 1000);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(out_tvalid), 64'(0));
        chk("arst_tdata", 64'(out_tdata), 64'(0));
        chk("arst_tlast", 64'(out_tlast), 64'(0));
        chk("arst_tready", 64'(in_tready), 64'(0));
        chk("arst_seg", 64'(seg_count), 64'(0));
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("post_rst_idle", 64'(out_tvalid), 64'(0));
        restart_model();
        gain_m = 1024; pilot_m = 1'b1; mon_en = 1'b1;
        sr_write(DEF_CTRL_ADDR, 32'd3);
        wait_words(4, 100);
        if (obs_q.size() >= 1) chk("post_rst_sync", 64'(obs_q[0]), 64'({1'b0, 32'h19000000}));
        stop_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
